// File: rtl/regs_wb_sched.sv
// Register-file writeback scheduler: round-robin arbitration of NR_REQ requesters onto one
// write port plus a per-register pending-write scoreboard. Optional forwarding: REGS_WB_SCHED_FWD_EN.
module regs_wb_sched #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NR_REGS    = 32,
    parameter int unsigned NR_REQ     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_valid,
    input  logic [ADDR_WIDTH-1:0]      iss_addr,
    input  logic [NR_REQ-1:0]          req_valid,
    input  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NR_REQ*WIDTH-1:0]    req_data,
    output logic [NR_REQ-1:0]          req_ready,
    output logic                       we,
    output logic [ADDR_WIDTH-1:0]      addrw,
    output logic [WIDTH-1:0]           dinw,
    input  logic [ADDR_WIDTH-1:0]      rd_addra,
    input  logic [ADDR_WIDTH-1:0]      rd_addrb,
    output logic                       busya,
    output logic                       busyb,
`ifdef REGS_WB_SCHED_FWD_EN
    output logic                       fwda,
    output logic                       fwdb,
    output logic [WIDTH-1:0]           fwd_data,
`endif
    output logic [NR_REGS-1:0]         busy_vec
);

    localparam int unsigned PtrW = $clog2(NR_REQ);

    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [PtrW-1:0]       idx_hi, idx_lo, gnt_idx;
    logic                  found_hi, gnt_any;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [WIDTH-1:0]      gnt_data;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addrw_q;
    logic [WIDTH-1:0]      dinw_q;
    logic [NR_REGS-1:0]    busy_q, busy_d;
    logic                  busya_raw, busyb_raw;

    // Round robin: lowest valid index at or above the pointer, else lowest valid index overall.
    always_comb begin
        found_hi = 1'b0;
        gnt_any  = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            if (req_valid[i] && !found_hi && (PtrW'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                idx_hi   = PtrW'(i);
            end
            if (req_valid[i] && !gnt_any) begin
                gnt_any = 1'b1;
                idx_lo  = PtrW'(i);
            end
        end
        gnt_idx   = found_hi ? idx_hi : idx_lo;
        req_ready = gnt_any ? (NR_REQ'(1) << gnt_idx) : '0;
        ptr_d     = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PtrW'(NR_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
        end
    end

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            if (PtrW'(i) == gnt_idx) begin
                gnt_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Set after clear so a newly issued writer keeps its bit on a same-edge collision.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NR_REGS; r++) begin
            if (we_q && addrw_q == ADDR_WIDTH'(r)) busy_d[r] = 1'b0;
            if (iss_valid && iss_addr == ADDR_WIDTH'(r)) busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addrw_q <= '0;
            dinw_q  <= '0;
            busy_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            // Writes to x0 are granted but dropped; the address/data registers keep their value.
            we_q   <= gnt_any && (gnt_addr != '0);
            if (gnt_any && (gnt_addr != '0)) begin
                addrw_q <= gnt_addr;
                dinw_q  <= gnt_data;
            end
        end
    end

    always_comb begin
        busya_raw = 1'b0;
        busyb_raw = 1'b0;
        for (int unsigned r = 0; r < NR_REGS; r++) begin
            if (rd_addra == ADDR_WIDTH'(r)) busya_raw = busy_q[r];
            if (rd_addrb == ADDR_WIDTH'(r)) busyb_raw = busy_q[r];
        end
    end

`ifdef REGS_WB_SCHED_FWD_EN
    assign fwda     = we_q && (addrw_q == rd_addra) && (addrw_q != '0);
    assign fwdb     = we_q && (addrw_q == rd_addrb) && (addrw_q != '0);
    assign fwd_data = dinw_q;
    assign busya    = busya_raw && !fwda;
    assign busyb    = busyb_raw && !fwdb;
`else
    assign busya    = busya_raw;
    assign busyb    = busyb_raw;
`endif

    assign we       = we_q;
    assign addrw    = addrw_q;
    assign dinw     = dinw_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Directed bench for regs_wb_sched: arbitration, write timing, scoreboard, x0 and reset.
module tb_regs_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        we;
    logic [4:0]  addrw;
    logic [31:0] dinw;
    logic [4:0]  rd_addra, rd_addrb;
    logic        busya, busyb;
    logic [31:0] busy_vec;
`ifdef REGS_WB_SCHED_FWD_EN
    logic        fwda, fwdb;
    logic [31:0] fwd_data;
`endif

    int vectors = 0;
    int miscompares = 0;

    regs_wb_sched dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we        (we),
        .addrw     (addrw),
        .dinw      (dinw),
        .rd_addra  (rd_addra),
        .rd_addrb  (rd_addrb),
        .busya     (busya),
        .busyb     (busyb),
`ifdef REGS_WB_SCHED_FWD_EN
        .fwda      (fwda),
        .fwdb      (fwdb),
        .fwd_data  (fwd_data),
`endif
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; iss_valid = 1'b0; iss_addr = '0; req_valid = '0;
        req_addr = '0; req_data = '0; rd_addra = '0; rd_addrb = '0;
        step(); step();
        check("rst_we", we, 0);
        check("rst_addrw", addrw, 0);
        check("rst_dinw", dinw, 0);
        check("rst_busy", busy_vec, 0);
        check("rst_ready_idle", req_ready, 0);
        rst = 1'b1;
        step();

        // Round robin with both requesters held valid
        req_addr = {5'd7, 5'd3};
        req_data = {32'h5555, 32'hAAAA};
        req_valid = 2'b11;
        #1 check("rr_g0", req_ready, 2'b01);
        step();
        check("rr_we0", we, 1); check("rr_a0", addrw, 3); check("rr_d0", dinw, 32'hAAAA);
        check("rr_g1", req_ready, 2'b10);
        step();
        check("rr_a1", addrw, 7); check("rr_d1", dinw, 32'h5555);
        check("rr_g2", req_ready, 2'b01);
        step();
        check("rr_we2", we, 1); check("rr_a2", addrw, 3);
        check("rr_g3", req_ready, 2'b10);
        step();
        check("rr_a3", addrw, 7);
        req_valid = 2'b00;
        #1 check("rr_idle_ready", req_ready, 2'b00);
        step();
        check("rr_idle_we", we, 0); check("rr_hold_addrw", addrw, 7);
        check("rr_hold_dinw", dinw, 32'h5555); check("rr_busy", busy_vec, 0);

        // Mid-operation reset: pointer is at 1 and a write is in flight
        req_valid = 2'b01; iss_valid = 1'b1; iss_addr = 5'd4;
        step();
        req_valid = 2'b00; iss_valid = 1'b0;
        check("mr_we_before", we, 1); check("mr_busy_before", busy_vec, 32'h10);
        #2 rst = 1'b0;
        #1 check("mr_we", we, 0); check("mr_addrw", addrw, 0);
        check("mr_dinw", dinw, 0); check("mr_busy", busy_vec, 0);
        #1 rst = 1'b1;
        req_valid = 2'b11;
        #1 check("mr_first_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("mr_post_we", we, 1); check("mr_post_addrw", addrw, 3);
        step();

        // Scoreboard life of x5; pointer is at 1
        iss_valid = 1'b1; iss_addr = 5'd5; rd_addra = 5'd5;
        #1 check("sb_c0_busya", busya, 0);
        step();
        iss_valid = 1'b0;
        check("sb_c1_busya", busya, 1); check("sb_c1_vec", busy_vec, 32'h20);
        step();
        step();
        req_addr = {5'd5, 5'd0}; req_data = {32'h1234, 32'h0}; req_valid = 2'b10;
        #1 check("sb_c3_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        check("sb_c4_we", we, 1); check("sb_c4_addrw", addrw, 5); check("sb_c4_dinw", dinw, 32'h1234);
`ifdef REGS_WB_SCHED_FWD_EN
        check("sb_c4_busya", busya, 0); check("sb_c4_fwda", fwda, 1);
        check("sb_c4_fwd_data", fwd_data, 32'h1234);
`else
        check("sb_c4_busya", busya, 1);
`endif
        step();
        check("sb_c5_busya", busya, 0); check("sb_c5_vec", busy_vec, 0); check("sb_c5_we", we, 0);

        // Set/clear collision on x9; pointer is at 0
        req_addr = {5'd0, 5'd9}; req_data = {32'h0, 32'h99}; req_valid = 2'b01;
        step();
        req_valid = 2'b00; iss_valid = 1'b1; iss_addr = 5'd9; rd_addrb = 5'd9;
        check("col_we", we, 1); check("col_addrw", addrw, 9);
        step();
        iss_valid = 1'b0;
        check("col_vec", busy_vec, 32'h200); check("col_busyb", busyb, 1);
        req_addr = {5'd9, 5'd0}; req_valid = 2'b10;
        #1 check("col_clr_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
        check("col_cleared", busy_vec, 0); check("col_busyb_clr", busyb, 0);

        // x0: request granted but write dropped; issue to x0 sets nothing. Pointer is at 0
        req_addr = {5'd0, 5'd0}; req_data = {32'h0, 32'hFFFF}; req_valid = 2'b01;
        #1 check("z_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("z_we", we, 0);
        iss_valid = 1'b1; iss_addr = 5'd0; rd_addra = 5'd0;
        step();
        iss_valid = 1'b0;
        check("z_vec", busy_vec, 0); check("z_busya", busya, 0);

        // Single requester streaming; pointer is at 1
        req_addr = {5'd1, 5'd0}; req_data = {32'h11, 32'h0}; req_valid = 2'b10;
        #1 check("st_g0", req_ready, 2'b10);
        step();
        check("st_we1", we, 1); check("st_a1", addrw, 1); check("st_d1", dinw, 32'h11);
        req_addr = {5'd2, 5'd0}; req_data = {32'h22, 32'h0};
        #1 check("st_g1", req_ready, 2'b10);
        step();
        check("st_we2", we, 1); check("st_a2", addrw, 2); check("st_d2", dinw, 32'h22);
        req_addr = {5'd3, 5'd0}; req_data = {32'h33, 32'h0};
        step();
        check("st_we3", we, 1); check("st_a3", addrw, 3); check("st_d3", dinw, 32'h33);
        req_valid = 2'b11;
        #1 check("st_ptr0", req_ready, 2'b01);
        req_valid = 2'b00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
